yildiz_prog_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the YildizCPU16 memory load port (`we_in`/`sel_in`/`adr_in`/`data_in`). It parses framed bytes from a serial receiver, assembles 16-bit big-endian words, and writes them into CPU memory at consecutive 12-bit addresses. It holds the CPU halted while a frame is in progress and reports completion or checksum failure. This replaces the hand-driven memory preload used in simulation with a loader that also works in hardware.

---
 rtl/yildiz_pkg.sv | 24 ++
 rtl/yildiz_prog_loader.sv | 151 +++++++++++++++
 tb/tb_yildiz_prog_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/yildiz_pkg.sv
// Shared definitions for the YildizCPU16 program loader: widths, frame constants
// and the loader FSM state encoding.
package yildiz_pkg;

  localparam int          ADDR_W   = 12;
  localparam int          DATA_W   = 16;
  localparam int          SEL_W    = 8;
  localparam logic [7:0]  SEL_PROG = 8'h01;
  localparam logic [7:0]  HEADER   = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADR_HI,
    ST_ADR_LO,
    ST_CNT,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/yildiz_prog_loader.sv
// Framed byte-stream loader: parses HEADER/address/count/words/checksum and writes
// big-endian words into CPU memory, holding the CPU halted until a good frame lands.
module yildiz_prog_loader #(
  parameter int         ADDR_W   = yildiz_pkg::ADDR_W,
  parameter int         DATA_W   = yildiz_pkg::DATA_W,
  parameter int         SEL_W    = yildiz_pkg::SEL_W,
  parameter logic [7:0] SEL_PROG = yildiz_pkg::SEL_PROG,
  parameter logic [7:0] HEADER   = yildiz_pkg::HEADER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);
  import yildiz_pkg::*;

  state_e              state_q, state_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;
  logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
  logic                rx_ready_q, rx_ready_d;
  logic                busy_q, busy_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                acc;
  logic [7:0]          sum_next;

  assign acc      = rx_valid && rx_ready_q;
  assign sum_next = sum_q + rx_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (acc && rx_data == HEADER) state_d = ST_ADR_HI;
      ST_ADR_HI:  if (acc) state_d = ST_ADR_LO;
      ST_ADR_LO:  if (acc) state_d = ST_CNT;
      ST_CNT:     if (acc) state_d = (rx_data == 8'h00) ? ST_CSUM : ST_DATA_HI;
      ST_DATA_HI: if (acc) state_d = ST_DATA_LO;
      ST_DATA_LO: if (acc) state_d = ST_WRITE;
      // cnt_q was already decremented when the lo byte arrived
      ST_WRITE:   state_d = (cnt_q == 8'h00) ? ST_CSUM : ST_DATA_HI;
      ST_CSUM:    if (acc) state_d = (sum_next == 8'h00) ? ST_DONE : ST_ERR;
      ST_DONE:    state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    mem_adr_d  = mem_adr_q;
    mem_data_d = mem_data_q;
    hold_d     = hold_q;

    // Outputs are registered from the next state so they line up with it
    mem_we_d   = (state_d == ST_WRITE);
    mem_sel_d  = mem_we_d ? SEL_W'(SEL_PROG) : '0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    rx_ready_d = (state_d != ST_WRITE) && (state_d != ST_DONE) && (state_d != ST_ERR);

    if (state_q == ST_IDLE) sum_d = 8'h00;
    else if (acc)           sum_d = sum_next;

    case (state_q)
      ST_IDLE:    if (state_d == ST_ADR_HI) hold_d = 1'b1;
      ST_ADR_HI:  if (acc) addr_d[ADDR_W-1:8] = rx_data[ADDR_W-9:0];
      ST_ADR_LO:  if (acc) addr_d[7:0] = rx_data;
      ST_CNT:     if (acc) cnt_d = rx_data;
      ST_DATA_HI: if (acc) hi_d = rx_data;
      ST_DATA_LO: begin
        if (acc) begin
          mem_adr_d  = addr_q;
          mem_data_d = {hi_q, rx_data};
          cnt_d      = cnt_q - 8'd1;
        end
      end
      ST_WRITE:   addr_d = addr_q + 1'b1;
      default:    ;
    endcase

    if (state_d == ST_DONE) hold_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      mem_adr_q  <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      mem_sel_q  <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      mem_adr_q  <= mem_adr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      mem_sel_q  <= mem_sel_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_adr   = mem_adr_q;
  assign mem_data  = mem_data_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_yildiz_prog_loader.sv
// Scoreboard bench for yildiz_prog_loader: a frame-level reference model predicts
// memory writes and completion status; an independent monitor checks the DUT.
module tb_yildiz_prog_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];
  typedef struct { logic [11:0] adr; logic [15:0] data; } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, cpu_hold, busy, load_done, load_err;
  logic [7:0]  mem_sel;
  logic [11:0] mem_adr;
  logic [15:0] mem_data;

  wr_t  wq[$];
  bit   eq[$];
  logic exp_hold = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;

  yildiz_prog_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_adr(mem_adr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Monitor: compares every write strobe and status pulse against the queues
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("no_write_expected", {31'd0, mem_we}, 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_adr", {20'd0, mem_adr}, {20'd0, w.adr});
          chk("write_data", {16'd0, mem_data}, {16'd0, w.data});
          chk("write_sel", {24'd0, mem_sel}, 32'h01);
        end
      end
      if (load_done || load_err) begin
        if (eq.size() == 0) chk("no_status_expected", {30'd0, load_done, load_err}, 32'd0);
        else begin
          bit ok;
          ok = eq.pop_front();
          chk("status", {30'd0, load_done, load_err}, ok ? 32'd2 : 32'd1);
        end
      end
    end
  end

  // Reference model: parse a byte list at frame level and predict its effects
  task automatic predict(input bq_t f);
    int h;
    logic [11:0] adr;
    int cnt;
    int sum;
    h = 0;
    while (h < f.size() && f[h] != 8'hA5) h++;
    adr = {f[h+1][3:0], f[h+2]};
    cnt = f[h+3];
    for (int i = 0; i < cnt; i++) begin
      wr_t w;
      w.adr  = 12'((int'(adr) + i) % 4096);
      w.data = {f[h+4+2*i], f[h+5+2*i]};
      wq.push_back(w);
    end
    sum = 0;
    for (int i = h + 1; i < f.size(); i++) sum += f[i];
    eq.push_back((sum % 256) == 0);
    exp_hold = ((sum % 256) == 0) ? 1'b0 : 1'b1;
  endtask

  task automatic make_frame(input logic [7:0] ahi, input logic [7:0] alo, input wq_t w,
                            input logic [7:0] csum_off, output bq_t f);
    logic [7:0] s;
    f = {};
    f.push_back(8'hA5); f.push_back(ahi); f.push_back(alo); f.push_back(8'(w.size()));
    s = ahi + alo + 8'(w.size());
    foreach (w[i]) begin
      f.push_back(w[i][15:8]); f.push_back(w[i][7:0]);
      s = s + w[i][15:8] + w[i][7:0];
    end
    f.push_back(8'(-s) + csum_off);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    forever begin
      #4;
      if (rx_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t f, input int maxgap);
    foreach (f[i]) send_byte(f[i], $urandom_range(maxgap, 0));
  endtask

  task automatic settle_and_check(input string nm);
    for (int i = 0; i < 40 && (wq.size() != 0 || eq.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({nm, "_drained"}, wq.size() + eq.size(), 32'd0);
    chk({nm, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input string nm, input bq_t f, input int maxgap);
    predict(f);
    send_bytes(f, maxgap);
    settle_and_check(nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({nm, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({nm, "_mem_sel"}, {24'd0, mem_sel}, 32'd0);
    chk({nm, "_mem_adr"}, {20'd0, mem_adr}, 32'd0);
    chk({nm, "_mem_data"}, {16'd0, mem_data}, 32'd0);
    chk({nm, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done_err"}, {30'd0, load_done, load_err}, 32'd0);
  endtask

  initial begin
    bq_t f;
    wq_t w;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reference frame, back-to-back then with random gaps
    f = {8'hA5, 8'h00, 8'h10, 8'h02, 8'h0A, 8'h05, 8'h12, 8'h50, 8'h7D};
    run_frame("frame_a", f, 0);
    run_frame("frame_a_gaps", f, 3);

    // Bad checksum: writes still land, hold stays until next good frame
    f = {8'hA5, 8'h00, 8'h10, 8'h02, 8'h0A, 8'h05, 8'h12, 8'h50, 8'h7E};
    run_frame("frame_bad", f, 1);
    f = {8'hA5, 8'h00, 8'h10, 8'h02, 8'h0A, 8'h05, 8'h12, 8'h50, 8'h7D};
    run_frame("frame_recover", f, 1);

    // Address wrap, with ignored upper nibble set
    w = {16'hBEEF, 16'h1234};
    make_frame(8'h3F, 8'hFF, w, 8'h00, f);
    run_frame("frame_wrap", f, 2);

    // Zero-count frame
    w = {};
    make_frame(8'h04, 8'h56, w, 8'h00, f);
    run_frame("frame_cnt0", f, 2);

    // Garbage before header, including a mid-frame header byte as data
    f = {8'h00, 8'hFF, 8'h12};
    send_bytes(f, 1);
    repeat (2) @(negedge clk);
    chk("garbage_busy", {31'd0, busy}, 32'd0);
    w = {16'hA5A5, 16'h00A5};
    make_frame(8'h01, 8'h20, w, 8'h00, f);
    run_frame("frame_hdr_data", f, 2);

    // Reset after the first data word of a three-word frame
    wq.push_back('{adr: 12'h020, data: 16'hCAFE});
    f = {8'hA5, 8'h00, 8'h20, 8'h03, 8'hCA, 8'hFE};
    send_bytes(f, 0);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    chk("midframe_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(negedge clk);
    chk("midframe_write_seen", wq.size(), 32'd0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    wq.delete();
    eq.delete();
    exp_hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    w = {16'h1111, 16'h2222, 16'h3333};
    make_frame(8'h00, 8'h20, w, 8'h00, f);
    run_frame("frame_after_reset", f, 2);

    // Randomized frames, some with corrupted checksums
    for (int k = 0; k < 8; k++) begin
      logic [7:0] off;
      w = {};
      for (int i = 0; i < $urandom_range(4, 0); i++) w.push_back(16'($urandom));
      off = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      make_frame(8'($urandom), 8'($urandom), w, off, f);
      run_frame("frame_rand", f, 3);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
